// File: rtl/riscv_dmem_bridge_pkg.sv
// ----------------------------------------------------------------------------
// riscv_dmem_bridge_pkg : shared size codes, FSM states, alignment helper. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package riscv_dmem_bridge_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_DM_IDLE = 3'd0,
        ST_DM_REQ  = 3'd1,
        ST_DM_RSP  = 3'd2,
        ST_DM_DONE = 3'd3,
        ST_DM_ERR  = 3'd4
    } dm_state_e;

    // Size code 3 is treated as a word everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = off[0];
            default:   mis = |off;
        endcase
        return mis;
    endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_dmem_bridge_if.sv
// ----------------------------------------------------------------------------
// riscv_dmem_bridge_if : valid/ready word bus between bridge and memory. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface riscv_dmem_bridge_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic        valid;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output addr, wdata, be, we, valid,
        input  ready, rvalid, rdata, err
    );

    modport slave (
        input  addr, wdata, be, we, valid,
        output ready, rvalid, rdata, err
    );
endinterface

`default_nettype wire

// File: rtl/riscv_dmem_bridge_lane.sv
// ----------------------------------------------------------------------------
// riscv_dmem_lane : byte-lane steering for writes and LSB alignment for reads. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module riscv_dmem_lane
    import riscv_dmem_bridge_pkg::*;
(
    input  wire logic [1:0]  wr_size,
    input  wire logic [1:0]  wr_off,
    input  wire logic [31:0] wdata_in,
    output logic      [3:0]  be,
    output logic      [31:0] wdata_out,
    input  wire logic [1:0]  rd_size,
    input  wire logic [1:0]  rd_off,
    input  wire logic [31:0] rdata_in,
    output logic      [31:0] rdata_out
);

    logic [31:0] rd_shifted;

    always_comb begin
        be        = 4'hF;
        wdata_out = wdata_in;
        case (wr_size)
            SIZE_BYTE: begin
                be        = 4'b0001 << wr_off;
                wdata_out = {4{wdata_in[7:0]}};
            end
            SIZE_HALF: begin
                be        = 4'b0011 << {wr_off[1], 1'b0};
                wdata_out = {2{wdata_in[15:0]}};
            end
            default: begin
                be        = 4'hF;
                wdata_out = wdata_in;
            end
        endcase
    end

    always_comb begin
        rd_shifted = rdata_in >> {rd_off, 3'b000};
        case (rd_size)
            SIZE_BYTE: rdata_out = {24'b0, rd_shifted[7:0]};
            SIZE_HALF: rdata_out = {16'b0, rd_shifted[15:0]};
            default:   rdata_out = rd_shifted;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/riscv_dmem_bridge.sv
// ----------------------------------------------------------------------------
// riscv_dmem_bridge : core load/store pulse to valid/ready word bus with timeout. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module riscv_dmem_bridge
    import riscv_dmem_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic        clk_i,
    input  wire logic        reset_i,
    input  wire logic [31:0] daddr_i,
    input  wire logic [31:0] dwdata_i,
    input  wire logic [1:0]  dsize_i,
    input  wire logic        drd_i,
    input  wire logic        dwr_i,
    output logic      [31:0] drdata_o,
    output logic             dstall_o,
    output logic             derr_o,
    riscv_dmem_bridge_if.master bus
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    dm_state_e   state, state_nx;
    logic [7:0]  tmo_cnt;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        both_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] drdata_q;

    logic        req;
    logic        timeout;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;

    assign req     = drd_i | dwr_i;
    assign timeout = (tmo_cnt >= TO_LAST);

    // Write lanes come from the live core inputs (captured in IDLE); read
    // alignment uses the captured offset/size while the response arrives.
    riscv_dmem_lane u_lane (
        .wr_size   (dsize_i),
        .wr_off    (daddr_i[1:0]),
        .wdata_in  (dwdata_i),
        .be        (lane_be),
        .wdata_out (lane_wdata),
        .rd_size   (size_q),
        .rd_off    (off_q),
        .rdata_in  (bus.rdata),
        .rdata_out (lane_rdata)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state    <= ST_DM_IDLE;
            tmo_cnt  <= 8'd0;
            off_q    <= 2'd0;
            size_q   <= 2'd0;
            we_q     <= 1'b0;
            both_q   <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            be_q     <= 4'd0;
            drdata_q <= 32'd0;
        end else begin
            state <= state_nx;

            if (state == ST_DM_IDLE)
                tmo_cnt <= 8'd0;
            else if ((state == ST_DM_REQ || state == ST_DM_RSP) && tmo_cnt != 8'hFF)
                tmo_cnt <= tmo_cnt + 8'd1;

            if (state == ST_DM_IDLE && req) begin
                off_q   <= daddr_i[1:0];
                size_q  <= dsize_i;
                we_q    <= dwr_i;
                both_q  <= drd_i & dwr_i;
                addr_q  <= {daddr_i[31:2], 2'b00};
                wdata_q <= lane_wdata;
                be_q    <= lane_be;
            end

            // A response only counts while the FSM is still waiting for it.
            if (state == ST_DM_RSP && bus.rvalid && !bus.err && !we_q)
                drdata_q <= lane_rdata;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_DM_IDLE: begin
                if (req)
                    state_nx = is_misaligned(dsize_i, daddr_i[1:0]) ? ST_DM_ERR : ST_DM_REQ;
            end
            ST_DM_REQ: begin
                if (bus.ready)
                    state_nx = ST_DM_RSP;
                else if (timeout)
                    state_nx = ST_DM_ERR;
            end
            ST_DM_RSP: begin
                if (bus.rvalid)
                    state_nx = bus.err ? ST_DM_ERR : ST_DM_DONE;
                else if (timeout)
                    state_nx = ST_DM_ERR;
            end
            ST_DM_DONE: state_nx = ST_DM_IDLE;
            ST_DM_ERR:  state_nx = ST_DM_IDLE;
            default:    state_nx = ST_DM_IDLE;
        endcase
    end

    assign bus.valid = (state == ST_DM_REQ);
    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;
    assign bus.be    = be_q;
    assign bus.we    = we_q;

    assign drdata_o  = drdata_q;
    assign dstall_o  = ((state == ST_DM_IDLE) && req) || (state == ST_DM_REQ) || (state == ST_DM_RSP);
    // A simultaneous read+write request is flagged when the write completes.
    assign derr_o    = (state == ST_DM_ERR) || ((state == ST_DM_DONE) && both_q);

endmodule

`default_nettype wire

// File: tb/tb_riscv_dmem_bridge.sv
// ----------------------------------------------------------------------------
// tb_riscv_dmem_bridge : directed and random transactions against a byte-lane model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_riscv_dmem_bridge;
    import riscv_dmem_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] daddr, dwdata;
    logic [1:0]  dsize;
    logic        drd, dwr;
    logic [31:0] drdata;
    logic        dstall, derr;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rdata = 32'd0;

    riscv_dmem_bridge_if bus_if ();

    riscv_dmem_bridge #(.TIMEOUT_CYCLES(255)) dut (
        .clk_i    (clk),
        .reset_i  (reset_n),
        .daddr_i  (daddr),
        .dwdata_i (dwdata),
        .dsize_i  (dsize),
        .drd_i    (drd),
        .dwr_i    (dwr),
        .drdata_o (drdata),
        .dstall_o (dstall),
        .derr_o   (derr),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == SIZE_BYTE) ? 1 : (sz == SIZE_HALF) ? 2 : 4;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
        int n = nbytes(sz);
        int off = int'(a[1:0]);
        return 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r;
        int n = nbytes(sz);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rdata(input logic [31:0] raw, input logic [1:0] sz,
                                              input logic [31:0] a);
        logic [63:0] mask = (64'd1 << (8 * nbytes(sz))) - 64'd1;
        logic [31:0] sh = raw >> (8 * int'(a[1:0]));
        return sh & mask[31:0];
    endfunction

    task automatic txn(input logic rd, input logic wr, input logic [31:0] a, input logic [1:0] sz,
                       input logic [31:0] d, input int rdy_dly, input int rsp_dly,
                       input logic [31:0] raw, input logic berr);
        logic mis = (int'(a[1:0]) % nbytes(sz)) != 0;
        @(negedge clk);
        drd = rd; dwr = wr; daddr = a; dsize = sz; dwdata = d;
        #1;
        chk("stall_req", dstall, 1'b1);
        chk("valid_idle", bus_if.valid, 1'b0);
        @(posedge clk);
        #1;
        drd = 1'b0; dwr = 1'b0; daddr = $urandom; dwdata = $urandom;
        if (mis) begin
            @(negedge clk);
            chk("mis_derr", derr, 1'b1);
            chk("mis_stall", dstall, 1'b0);
            chk("mis_valid", bus_if.valid, 1'b0);
            @(negedge clk);
            chk("mis_derr_clr", derr, 1'b0);
            return;
        end
        for (int i = 0; i <= rdy_dly; i++) begin
            @(negedge clk);
            chk("req_valid", bus_if.valid, 1'b1);
            chk("req_stall", dstall, 1'b1);
            chk("req_addr", bus_if.addr, {a[31:2], 2'b00});
            chk("req_be", bus_if.be, ref_be(sz, a));
            chk("req_wdata", bus_if.wdata, ref_wdata(sz, d));
            chk("req_we", bus_if.we, wr);
            if (i == rdy_dly) bus_if.ready = 1'b1;
        end
        @(posedge clk);
        #1 bus_if.ready = 1'b0;
        for (int i = 0; i <= rsp_dly; i++) begin
            @(negedge clk);
            chk("rsp_valid", bus_if.valid, 1'b0);
            chk("rsp_stall", dstall, 1'b1);
            if (i == rsp_dly) begin
                bus_if.rvalid = 1'b1; bus_if.rdata = raw; bus_if.err = berr;
            end
        end
        @(posedge clk);
        #1;
        bus_if.rvalid = 1'b0; bus_if.err = 1'b0; bus_if.rdata = $urandom;
        if (!wr && !berr) exp_rdata = ref_rdata(raw, sz, a);
        @(negedge clk);
        chk("end_derr", derr, berr | (rd & wr));
        chk("end_stall", dstall, 1'b0);
        chk("end_rdata", drdata, exp_rdata);
        @(negedge clk);
        chk("idle_derr", derr, 1'b0);
    endtask

    initial begin
        int cyc;
        reset_n = 1'b0;
        drd = 1'b0; dwr = 1'b0; daddr = 32'd0; dwdata = 32'd0; dsize = 2'd0;
        bus_if.ready = 1'b0; bus_if.rvalid = 1'b0; bus_if.rdata = 32'd0; bus_if.err = 1'b0;
        @(negedge clk);
        chk("rst_valid", bus_if.valid, 1'b0);
        chk("rst_stall", dstall, 1'b0);
        chk("rst_derr", derr, 1'b0);
        chk("rst_rdata", drdata, 32'd0);
        chk("rst_addr", bus_if.addr, 32'd0);
        chk("rst_be", bus_if.be, 4'd0);
        @(negedge clk);
        reset_n = 1'b1;

        txn(1'b0, 1'b1, 32'h100, SIZE_WORD, 32'h11223344, 0, 0, 32'h0, 1'b0);
        txn(1'b0, 1'b1, 32'h103, SIZE_BYTE, 32'h000000AB, 0, 0, 32'h0, 1'b0);
        txn(1'b1, 1'b0, 32'h103, SIZE_BYTE, 32'h0, 0, 0, 32'hAB000000, 1'b0);
        chk("lb_value", drdata, 32'h000000AB);
        txn(1'b1, 1'b0, 32'h101, SIZE_HALF, 32'h0, 0, 0, 32'h0, 1'b0);
        txn(1'b1, 1'b0, 32'h204, SIZE_WORD, 32'h0, 5, 1, 32'hCAFEF00D, 1'b1);
        chk("err_keeps_rdata", drdata, 32'h000000AB);
        txn(1'b1, 1'b1, 32'h206, SIZE_HALF, 32'h5566BEEF, 1, 0, 32'h0, 1'b0);

        // Response never arrives: abort after the cycle budget, then a late rvalid is ignored.
        @(negedge clk);
        drd = 1'b1; daddr = 32'h300; dsize = SIZE_WORD;
        @(posedge clk);
        #1 drd = 1'b0;
        @(negedge clk);
        chk("to_valid", bus_if.valid, 1'b1);
        bus_if.ready = 1'b1;
        @(posedge clk);
        #1 bus_if.ready = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!derr && cyc < 400);
        chk("to_cycles", cyc, 255);
        chk("to_derr", derr, 1'b1);
        chk("to_valid_low", bus_if.valid, 1'b0);
        @(negedge clk);
        chk("to_derr_clr", derr, 1'b0);
        bus_if.rvalid = 1'b1; bus_if.rdata = 32'hDEADBEEF;
        @(posedge clk);
        #1 bus_if.rvalid = 1'b0;
        @(negedge clk);
        chk("late_rdata", drdata, exp_rdata);
        chk("late_derr", derr, 1'b0);
        chk("late_stall", dstall, 1'b0);

        // Reset asserted while waiting for a read response.
        @(negedge clk);
        drd = 1'b1; daddr = 32'h400; dsize = SIZE_WORD;
        @(posedge clk);
        #1 drd = 1'b0;
        @(negedge clk);
        bus_if.ready = 1'b1;
        @(posedge clk);
        #1 bus_if.ready = 1'b0;
        @(negedge clk);
        chk("rsp_stall_pre", dstall, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus_if.valid, 1'b0);
        chk("mid_rst_stall", dstall, 1'b0);
        chk("mid_rst_rdata", drdata, 32'd0);
        chk("mid_rst_addr", bus_if.addr, 32'd0);
        exp_rdata = 32'd0;
        @(negedge clk);
        reset_n = 1'b1;
        bus_if.rvalid = 1'b1; bus_if.rdata = 32'h12345678;
        @(posedge clk);
        #1 bus_if.rvalid = 1'b0;
        @(negedge clk);
        chk("post_rst_rdata", drdata, 32'd0);
        chk("post_rst_derr", derr, 1'b0);

        for (int k = 0; k < 40; k++) begin
            int mode = $urandom_range(0, 5);
            logic rd = (mode != 1);
            logic wr = (mode == 1) || (mode == 5);
            txn(rd, wr, $urandom, 2'($urandom_range(0, 2)), $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom, ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
